// File: rtl/nto1_ddr_tx_framer_if.sv
// User-side and serializer-side signal bundle for the DDR transmit framer.
interface nto1_ddr_tx_framer_if #(
  parameter int unsigned S       = 8,
  parameter int unsigned D       = 4,
  parameter int unsigned FIFO_AW = 2
);

  logic [D*S-1:0]   in_data;
  logic             in_valid;
  logic             in_ready;
  logic             train_req;
  logic [D*S-1:0]   tx_data;
  logic             tx_data_vld;
  logic             training;
  logic [FIFO_AW:0] fifo_level;

  // Word source / observer side
  modport master (
    output in_data, in_valid, train_req,
    input  in_ready, tx_data, tx_data_vld, training, fifo_level
  );

  // Framer side
  modport slave (
    input  in_data, in_valid, train_req,
    output in_ready, tx_data, tx_data_vld, training, fifo_level
  );

endinterface

// File: rtl/nto1_ddr_tx_framer.sv
// Word-level transmit framer ahead of the DDR LVDS serializers: small FIFO,
// training bursts for far-end bitslip alignment, idle fill when no user data.
module nto1_ddr_tx_framer #(
  parameter int unsigned   S           = 8,
  parameter int unsigned   D           = 4,
  parameter logic [S-1:0]  TRAIN_PAT   = 8'h3C,
  parameter int unsigned   TRAIN_WORDS = 64,
  parameter int unsigned   FIFO_AW     = 2
) (
  input  logic gclk,
  input  logic reset,
  nto1_ddr_tx_framer_if.slave bus
);

  localparam int unsigned   DS        = D * S - 1;
  localparam int unsigned   DEPTH     = 2 ** FIFO_AW;
  localparam int unsigned   LW        = FIFO_AW + 1;
  localparam int unsigned   CW        = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [DS:0]   IDLE_WORD = {D{TRAIN_PAT}};
  localparam logic [CW-1:0] CNT_LOAD  = CW'(TRAIN_WORDS - 1);

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_next_cnt;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_not_full;

  logic [DS:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [DS:0]          r_tx_data;
  logic                 r_tx_vld;
  logic                 r_training;

  // Accept only below full; pushes during reset are discarded
  assign w_not_full   = (r_level != LW'(DEPTH));
  assign bus.in_ready = reset | w_not_full;
  assign w_push       = bus.in_valid & w_not_full & ~reset;

  // State and training counter register
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_state <= ST_TRAIN;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next state, counter and pop decision; train_req overrides everything
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop        = 1'b0;
    if (bus.train_req) begin
      w_next_state = ST_TRAIN;
      w_next_cnt   = CNT_LOAD;
    end else begin
      case (r_state)
        ST_TRAIN: begin
          if (r_cnt == '0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_cnt = r_cnt - CW'(1);
          end
        end
        ST_RUN: begin
          w_pop = (r_level != '0);
        end
        default: begin
          w_next_state = ST_TRAIN;
          w_next_cnt   = CNT_LOAD;
        end
      endcase
    end
  end

  // FIFO storage; stale contents are harmless because pointers are flushed
  always_ff @(posedge gclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered output word: popped user data, otherwise training/idle pattern
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_tx_data  <= IDLE_WORD;
      r_tx_vld   <= 1'b0;
      r_training <= 1'b1;
    end else begin
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_tx_vld  <= 1'b1;
      end else begin
        r_tx_data <= IDLE_WORD;
        r_tx_vld  <= 1'b0;
      end
      r_training <= (r_state == ST_TRAIN);
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_data_vld = r_tx_vld;
  assign bus.training    = r_training;
  assign bus.fifo_level  = r_level;

endmodule
